// File: rtl/mru_button_leds.sv
// mru_button_leds
//   Four-button / four-LED most-recently-used tracker. An internal divider
//   produces the timedClk square wave; buttons are sampled on each rising
//   edge of timedClk and a press is accepted when the same single button is
//   seen on two consecutive samples. Accepted buttons are kept in a 3-slot
//   table with recency ranks (0 = most recent); each resident button lights
//   its LED. A full-table miss evicts the most recent entry by default.
//
//   Compile-time option: define MRU_LRU_EVICT_EN to evict the least recently
//   used entry instead on a full-table miss.
//
// Parameters
//   TICK_HALF_CYCLES : clk cycles per half period of timedClk (>= 1)
// Ports
//   clk           : system clock, rising edge
//   rst           : synchronous reset, active high
//   b1..b4        : button levels, active high
//   l1..l4        : LED outputs, high while the matching button is resident
//   timedClk      : registered tick square wave
module mru_button_leds #(
    parameter int unsigned TICK_HALF_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic b4,
    output logic l1,
    output logic l2,
    output logic l3,
    output logic l4,
    output logic timedClk
);

    localparam int unsigned CW = (TICK_HALF_CYCLES > 1) ? $clog2(TICK_HALF_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_HALF_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          tick_q;
    logic          wrap;
    logic          sample;

    // Sample history: bit 3 = b1 ... bit 0 = b4
    logic [3:0]    cur;
    logic [3:0]    prev;
    logic [3:0]    lock;
    logic          one_hot;
    logic          confirm;
    logic [1:0]    btn_id;

    // Table state
    logic [2:0]    valid;
    logic [1:0]    slot_id   [3];
    logic [1:0]    slot_rank [3];
    logic [3:0]    led;

    // Next-table values
    logic [2:0]    nvalid;
    logic [1:0]    nslot_id   [3];
    logic [1:0]    nslot_rank [3];
    logic [3:0]    nled;
    logic          hit;
    logic [1:0]    hit_slot;
    logic          free_any;
    logic [1:0]    free_slot;
    logic [1:0]    victim;

    assign wrap   = (cnt == CNT_LAST);
    assign sample = wrap && !tick_q;
    assign cur    = {b1, b2, b3, b4};

    always_comb begin
        one_hot = 1'b0;
        btn_id  = 2'd0;
        unique case (cur)
            4'b1000: begin one_hot = 1'b1; btn_id = 2'd0; end
            4'b0100: begin one_hot = 1'b1; btn_id = 2'd1; end
            4'b0010: begin one_hot = 1'b1; btn_id = 2'd2; end
            4'b0001: begin one_hot = 1'b1; btn_id = 2'd3; end
            default: begin one_hot = 1'b0; btn_id = 2'd0; end
        endcase
    end

    // A button already confirmed in this hold stays locked until sampled low.
    assign confirm = one_hot && (cur == prev) && ((cur & lock) == 4'b0000);

    always_comb begin
        nvalid    = valid;
        hit       = 1'b0;
        hit_slot  = 2'd0;
        free_any  = 1'b0;
        free_slot = 2'd0;
        victim    = 2'd0;
        nled      = '0;
        for (int unsigned s = 0; s < 3; s++) begin
            nslot_id[s]   = slot_id[s];
            nslot_rank[s] = slot_rank[s];
        end

        for (int unsigned s = 0; s < 3; s++) begin
            if (valid[s] && slot_id[s] == btn_id) begin
                hit      = 1'b1;
                hit_slot = 2'(s);
            end
        end
        // Descending scan so the lowest free index wins.
        for (int unsigned s = 3; s > 0; s--) begin
            if (!valid[s-1]) begin
                free_any  = 1'b1;
                free_slot = 2'(s - 1);
            end
        end
`ifdef MRU_LRU_EVICT_EN
        // Table is full when this is used, so ranks are exactly 0,1,2.
        for (int unsigned s = 0; s < 3; s++) begin
            if (slot_rank[s] == 2'd2) victim = 2'(s);
        end
`else
        for (int unsigned s = 0; s < 3; s++) begin
            if (slot_rank[s] == 2'd0) victim = 2'(s);
        end
`endif

        if (confirm) begin
            if (hit) begin
                for (int unsigned s = 0; s < 3; s++) begin
                    if (valid[s] && slot_rank[s] < slot_rank[hit_slot])
                        nslot_rank[s] = slot_rank[s] + 2'd1;
                end
                nslot_rank[hit_slot] = 2'd0;
            end else if (free_any) begin
                for (int unsigned s = 0; s < 3; s++) begin
                    if (valid[s]) nslot_rank[s] = slot_rank[s] + 2'd1;
                end
                nvalid[free_slot]     = 1'b1;
                nslot_id[free_slot]   = btn_id;
                nslot_rank[free_slot] = 2'd0;
            end else begin
`ifdef MRU_LRU_EVICT_EN
                for (int unsigned s = 0; s < 3; s++) begin
                    if (2'(s) != victim) nslot_rank[s] = slot_rank[s] + 2'd1;
                end
                nslot_rank[victim] = 2'd0;
`endif
                // MRU eviction: the victim keeps rank 0, others unchanged.
                nslot_id[victim] = btn_id;
            end
        end

        for (int unsigned s = 0; s < 3; s++) begin
            if (nvalid[s]) nled[nslot_id[s]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            tick_q <= 1'b0;
            prev   <= '0;
            lock   <= '0;
            valid  <= '0;
            led    <= '0;
            for (int unsigned s = 0; s < 3; s++) begin
                slot_id[s]   <= '0;
                slot_rank[s] <= '0;
            end
        end else begin
            if (wrap) begin
                cnt    <= '0;
                tick_q <= ~tick_q;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (sample) begin
                prev  <= cur;
                lock  <= (lock & cur) | (confirm ? cur : 4'b0000);
                valid <= nvalid;
                led   <= nled;
                for (int unsigned s = 0; s < 3; s++) begin
                    slot_id[s]   <= nslot_id[s];
                    slot_rank[s] <= nslot_rank[s];
                end
            end
        end
    end

    assign timedClk = tick_q;
    assign l1 = led[0];
    assign l2 = led[1];
    assign l3 = led[2];
    assign l4 = led[3];

endmodule

// File: tb/tb_mru_button_leds.sv
module tb_mru_button_leds;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic b1, b2, b3, b4;
    logic l1, l2, l3, l4;
    logic timedClk;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MRU_LRU_EVICT_EN
    localparam logic [3:0] EXP_EVICT   = 4'b0111;
    localparam logic [3:0] MISS_BTN    = 4'b1000;
    localparam logic [3:0] EXP_REORDER = 4'b1101;
`else
    localparam logic [3:0] EXP_EVICT   = 4'b1101;
    localparam logic [3:0] MISS_BTN    = 4'b0010;
    localparam logic [3:0] EXP_REORDER = 4'b1011;
`endif

    mru_button_leds #(.TICK_HALF_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .l1(l1), .l2(l2), .l3(l3), .l4(l4),
        .timedClk(timedClk)
    );

    always #5 clk = ~clk;

    task automatic set_btn(input logic [3:0] v);
        {b1, b2, b3, b4} = v;
    endtask

    // Returns #1 after the clk edge on which timedClk falls.
    task automatic wait_fall();
        logic p;
        int n;
        p = timedClk;
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            if (p === 1'b1 && timedClk === 1'b0) break;
            p = timedClk;
            n++;
            if (n > 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_fall: timedClk fall not seen, got timeout, required fall within 20 clk");
                break;
            end
        end
    endtask

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) wait_fall();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_btn(4'bxxxx);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_leds: got %b required 0000", {l1, l2, l3, l4});
        end
        n_cmp++;
        if (timedClk !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tick: got %b required 0", timedClk);
        end
        rst = 1'b0;
        set_btn(4'b0000);
        wait_fall();
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_leds: got %b required 0000", {l1, l2, l3, l4});
        end
    endtask

    task automatic test_fill();
        set_btn(4'b1000);
        wait_fall();
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b0000) begin
            n_bad++;
            $display("FAIL b1_one_tick: got %b required 0000", {l1, l2, l3, l4});
        end
        wait_fall();
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b1000) begin
            n_bad++;
            $display("FAIL b1_two_ticks: got %b required 1000", {l1, l2, l3, l4});
        end
        set_btn(4'b0100);
        wait_fall();
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b1000) begin
            n_bad++;
            $display("FAIL b2_one_tick: got %b required 1000", {l1, l2, l3, l4});
        end
        wait_fall();
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b1100) begin
            n_bad++;
            $display("FAIL b2_fill: got %b required 1100", {l1, l2, l3, l4});
        end
        set_btn(4'b0010);
        wait_ticks(2);
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b1110) begin
            n_bad++;
            $display("FAIL b3_fill: got %b required 1110", {l1, l2, l3, l4});
        end
    endtask

    task automatic test_evict();
        set_btn(4'b0001);
        wait_ticks(2);
        n_cmp++;
        if ({l1, l2, l3, l4} !== EXP_EVICT) begin
            n_bad++;
            $display("FAIL evict: got %b required %b", {l1, l2, l3, l4}, EXP_EVICT);
        end
    endtask

    task automatic test_no_press();
        set_btn(4'b1100);
        for (int i = 0; i < 3; i++) begin
            wait_fall();
            n_cmp++;
            if ({l1, l2, l3, l4} !== EXP_EVICT) begin
                n_bad++;
                $display("FAIL multi_press tick %0d: got %b required %b", i, {l1, l2, l3, l4}, EXP_EVICT);
            end
        end
        set_btn(4'b0100);
        wait_fall();
        set_btn(4'b0000);
        wait_fall();
        n_cmp++;
        if ({l1, l2, l3, l4} !== EXP_EVICT) begin
            n_bad++;
            $display("FAIL short_press: got %b required %b", {l1, l2, l3, l4}, EXP_EVICT);
        end
    endtask

    task automatic test_long_hold();
        set_btn(4'b0001);
        wait_ticks(5);
        n_cmp++;
        if ({l1, l2, l3, l4} !== EXP_EVICT) begin
            n_bad++;
            $display("FAIL long_hold: got %b required %b", {l1, l2, l3, l4}, EXP_EVICT);
        end
        set_btn(4'b0000);
        wait_fall();
        set_btn(4'b0001);
        wait_ticks(2);
        n_cmp++;
        if ({l1, l2, l3, l4} !== EXP_EVICT) begin
            n_bad++;
            $display("FAIL rehit_b4: got %b required %b", {l1, l2, l3, l4}, EXP_EVICT);
        end
    endtask

    task automatic test_hit_reorder();
        set_btn(4'b0000);
        wait_fall();
        set_btn(4'b0100);
        wait_ticks(2);
        n_cmp++;
        if ({l1, l2, l3, l4} !== EXP_EVICT) begin
            n_bad++;
            $display("FAIL hit_b2: got %b required %b", {l1, l2, l3, l4}, EXP_EVICT);
        end
        set_btn(4'b0000);
        wait_fall();
        set_btn(MISS_BTN);
        wait_ticks(2);
        n_cmp++;
        if ({l1, l2, l3, l4} !== EXP_REORDER) begin
            n_bad++;
            $display("FAIL evict_after_hit: got %b required %b", {l1, l2, l3, l4}, EXP_REORDER);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        set_btn(4'b0000);
        wait_fall();
        set_btn(4'b0010);
        n = 0;
        while (timedClk !== 1'b1 && n <= 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (timedClk !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_rise: got %b required 1 within 20 clk", timedClk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_reset_leds: got %b required 0000", {l1, l2, l3, l4});
        end
        n_cmp++;
        if (timedClk !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_tick: got %b required 0", timedClk);
        end
        wait_fall();
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b0000) begin
            n_bad++;
            $display("FAIL post_reset_first: got %b required 0000", {l1, l2, l3, l4});
        end
        wait_fall();
        n_cmp++;
        if ({l1, l2, l3, l4} !== 4'b0010) begin
            n_bad++;
            $display("FAIL post_reset_second: got %b required 0010", {l1, l2, l3, l4});
        end
    endtask

    initial begin
        set_btn(4'b0000);
        test_reset();
        test_fill();
        test_evict();
        test_no_press();
        test_long_hold();
        test_hit_reorder();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
